// File: rtl/life_pkg.sv
// Shared types for the Game of Life generation engine: board geometry, row type and FSM states.
package life_pkg;

    localparam int N_ROWS = 8;

    typedef logic [7:0] row_t;
    typedef row_t [N_ROWS-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        SWAP
    } state_t;

endpackage

// File: rtl/generation_engine_if.sv
// Host load/control/status signals plus the row exchange with the external decoder_top.
interface generation_engine_if;
    import life_pkg::*;

    logic       load_valid;
    logic [2:0] load_addr;
    row_t       load_data;
    logic       start;
    logic       run;
    row_t       row_in;
    row_t       row_a;
    row_t       row_b;
    row_t       next_row;
    logic [2:0] disp_addr;
    row_t       disp_bits;
    logic       busy;
    logic       done;
    logic       stable;
    logic [5:0] gen_count;

    modport slave (
        input  load_valid, load_addr, load_data, start, run, next_row, disp_addr,
        output row_in, row_a, row_b, disp_bits, busy, done, stable, gen_count
    );

    modport master (
        output load_valid, load_addr, load_data, start, run, next_row, disp_addr,
        input  row_in, row_a, row_b, disp_bits, busy, done, stable, gen_count
    );

endinterface

// File: rtl/period_timer.sv
// Hold-off counter for auto-run: expire pulses after PERIOD uncleared cycles with run held.
module period_timer #(
    parameter int PERIOD = 64
) (
    input  logic ph1,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(PERIOD - 1);

    logic [7:0] count;

    assign expire = run && !clear && (count == LAST);

    always_ff @(posedge ph1) begin
        if (reset || clear || !run || count == LAST) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/generation_engine.sv
// 8x8 toroidal Life board: rows are streamed through an external decoder into a shadow bank,
// then swapped into the visible bank in one cycle.
module generation_engine
    import life_pkg::*;
#(
    parameter int PERIOD = 64
) (
    input  logic ph1,
    input  logic reset,
    generation_engine_if.slave bus
);

    state_t     state;
    state_t     state_next;
    board_t     cur;
    board_t     nxt;
    logic [2:0] r;
    logic [5:0] gen_count;
    logic       stable;
    logic       done;
    logic       busy;
    logic       expire;
    logic       timer_clear;

    // The done cycle is excluded from the hold-off so auto-run gets PERIOD quiet cycles after it.
    assign busy        = (state != IDLE);
    assign timer_clear = busy || done || bus.load_valid || bus.start;

    period_timer #(
        .PERIOD(PERIOD)
    ) timer (
        .ph1   (ph1),
        .reset (reset),
        .run   (bus.run),
        .clear (timer_clear),
        .expire(expire)
    );

    assign bus.row_in    = cur[r];
    assign bus.row_a     = cur[r - 3'd1];
    assign bus.row_b     = cur[r + 3'd1];
    assign bus.disp_bits = cur[bus.disp_addr];
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.stable    = stable;
    assign bus.gen_count = gen_count;

    always_ff @(posedge ph1) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!bus.load_valid && (bus.start || expire)) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (r == 3'd7) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // r wraps 7->0 on the last COMPUTE edge, so IDLE and SWAP always present row 0 neighbours.
    always_ff @(posedge ph1) begin
        if (reset) begin
            cur       <= '0;
            nxt       <= '0;
            r         <= 3'd0;
            gen_count <= 6'd0;
            stable    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == SWAP);
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        cur[bus.load_addr] <= bus.load_data;
                    end
                end
                COMPUTE: begin
                    nxt[r] <= bus.next_row;
                    r      <= r + 3'd1;
                end
                SWAP: begin
                    cur       <= nxt;
                    stable    <= (nxt == cur);
                    gen_count <= gen_count + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
